// File: rtl/conway_pkg.sv
// Shared encodings for the Game-of-Life engine: command ops, FSM states,
// neighbour offset table and the standard Conway rule masks.
package conway_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_RANDOM = 2'd1,
    OP_STEP   = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SCAN,
    ST_COPY,
    ST_DONE
  } state_e;

  localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
  localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } nb_ofs_t;

  // Fixed neighbour visiting order as (dx, dy) pairs.
  function automatic nb_ofs_t nb_ofs(input logic [2:0] idx);
    nb_ofs_t o;
    case (idx)
      3'd0:    o = '{dx: 2'sb11, dy: 2'sb01};
      3'd1:    o = '{dx: 2'sb00, dy: 2'sb01};
      3'd2:    o = '{dx: 2'sb01, dy: 2'sb01};
      3'd3:    o = '{dx: 2'sb11, dy: 2'sb00};
      3'd4:    o = '{dx: 2'sb01, dy: 2'sb00};
      3'd5:    o = '{dx: 2'sb11, dy: 2'sb11};
      3'd6:    o = '{dx: 2'sb00, dy: 2'sb11};
      default: o = '{dx: 2'sb01, dy: 2'sb11};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/conway_neigh_addr.sv
// Neighbour address generator: maps a cell address and neighbour index to the
// neighbour's address, flagging off-board neighbours when wrapping is off.
module conway_neigh_addr
  import conway_pkg::*;
#(
  parameter int unsigned LOG_W = 3,
  parameter int unsigned LOG_H = 3,
  localparam int unsigned AW = LOG_W + LOG_H
) (
  input  logic [AW-1:0] i_cell_addr,
  input  logic [2:0]    i_nb_idx,
  input  logic          i_wrap_en,
  output logic [AW-1:0] o_nb_addr,
  output logic          o_nb_valid
);

  nb_ofs_t                 w_ofs;
  logic signed [LOG_W:0]   w_dx;
  logic signed [LOG_H:0]   w_dy;
  logic [LOG_W:0]          w_x_ext;
  logic [LOG_H:0]          w_y_ext;

  // One extra bit per coordinate: it is set exactly when the sum lands at -1 or
  // at the board size, and the low bits are already the wrapped coordinate.
  always_comb begin
    w_ofs      = nb_ofs(i_nb_idx);
    w_dx       = (LOG_W+1)'(signed'(w_ofs.dx));
    w_dy       = (LOG_H+1)'(signed'(w_ofs.dy));
    w_x_ext    = {1'b0, i_cell_addr[LOG_W-1:0]} + w_dx;
    w_y_ext    = {1'b0, i_cell_addr[AW-1:LOG_W]} + w_dy;
    o_nb_addr  = {w_y_ext[LOG_H-1:0], w_x_ext[LOG_W-1:0]};
    o_nb_valid = i_wrap_en | ~(w_x_ext[LOG_W] | w_y_ext[LOG_H]);
  end

endmodule

// File: rtl/conway_engine.sv
// Game-of-Life engine: flop-array board with command sequencer for clear,
// random fill and single-generation step, plus host read/write ports.
module conway_engine
  import conway_pkg::*;
#(
  parameter int unsigned LOG_W = 3,
  parameter int unsigned LOG_H = 3,
  parameter int unsigned GEN_W = 16,
  localparam int unsigned AW = LOG_W + LOG_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [8:0]       birth_mask,
  input  logic [8:0]       survive_mask,
  input  logic             wrap_en,
  input  logic             rand_bit,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_data,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] generation,
  output logic [AW:0]      population
);

  localparam int unsigned N          = 1 << AW;
  localparam logic [3:0]  DECIDE_IDX = 4'd8;

  state_e           r_state, w_state_nxt;
  logic [N-1:0]     r_board, r_next;
  logic [AW-1:0]    r_addr;
  logic [3:0]       r_nidx, r_cnt;
  logic [8:0]       r_birth, r_surv;
  logic             r_wrap, r_fill_rand;
  logic             r_ready, r_busy, r_done, r_rd_data;
  logic [GEN_W-1:0] r_gen;
  logic [AW:0]      r_pop;
  logic [AW-1:0]    w_nb_addr;
  logic             w_nb_valid, w_nb_bit, w_last_cell, w_decide;
  logic             w_host_wr, w_fill_bit, w_new_cell;

  conway_neigh_addr #(.LOG_W(LOG_W), .LOG_H(LOG_H)) u_neigh (
    .i_cell_addr (r_addr),
    .i_nb_idx    (r_nidx[2:0]),
    .i_wrap_en   (r_wrap),
    .o_nb_addr   (w_nb_addr),
    .o_nb_valid  (w_nb_valid)
  );

  assign w_last_cell = &r_addr;
  assign w_decide    = (r_nidx == DECIDE_IDX);
  assign w_host_wr   = (r_state == ST_IDLE) && !cmd_valid && wr_en;
  assign w_fill_bit  = r_fill_rand & rand_bit;
  assign w_nb_bit    = w_nb_valid & r_board[w_nb_addr];
  assign w_new_cell  = r_board[r_addr] ? r_surv[r_cnt] : r_birth[r_cnt];

  assign cmd_ready  = r_ready;
  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_data    = r_rd_data;
  assign generation = r_gen;
  assign population = r_pop;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_CLEAR, OP_RANDOM: w_state_nxt = ST_FILL;
            OP_STEP:             w_state_nxt = ST_SCAN;
            default:             w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_FILL: if (w_last_cell)             w_state_nxt = ST_DONE;
      ST_SCAN: if (w_last_cell && w_decide) w_state_nxt = ST_COPY;
      ST_COPY: if (w_last_cell)             w_state_nxt = ST_DONE;
      default:                              w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Sequencer counters, latched command parameters and board statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_nidx      <= '0;
      r_cnt       <= '0;
      r_birth     <= '0;
      r_surv      <= '0;
      r_wrap      <= 1'b0;
      r_fill_rand <= 1'b0;
      r_gen       <= '0;
      r_pop       <= '0;
      r_rd_data   <= 1'b0;
    end else begin
      r_rd_data <= r_board[rd_addr];
      unique case (r_state)
        ST_IDLE: begin
          r_addr <= '0;
          r_nidx <= '0;
          r_cnt  <= '0;
          if (cmd_valid) begin
            r_birth     <= birth_mask;
            r_surv      <= survive_mask;
            r_wrap      <= wrap_en;
            r_fill_rand <= (cmd_op == OP_RANDOM);
          end else if (w_host_wr && (r_board[wr_addr] != wr_data)) begin
            r_pop <= wr_data ? r_pop + (AW+1)'(1) : r_pop - (AW+1)'(1);
          end
        end
        ST_FILL: begin
          r_gen  <= '0;
          r_pop  <= ((r_addr == '0) ? '0 : r_pop) + (AW+1)'(w_fill_bit);
          r_addr <= r_addr + AW'(1);
        end
        ST_SCAN: begin
          if (w_decide) begin
            r_nidx <= '0;
            r_cnt  <= '0;
            r_addr <= r_addr + AW'(1);
          end else begin
            r_nidx <= r_nidx + 4'd1;
            r_cnt  <= r_cnt + 4'(w_nb_bit);
          end
        end
        ST_COPY: begin
          r_pop  <= ((r_addr == '0) ? '0 : r_pop) + (AW+1)'(r_next[r_addr]);
          r_addr <= r_addr + AW'(1);
          if (w_last_cell) r_gen <= r_gen + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Committed board: host edits, fill writes and next-generation copy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_host_wr)                r_board[wr_addr] <= wr_data;
      else if (r_state == ST_FILL)  r_board[r_addr]  <= w_fill_bit;
      else if (r_state == ST_COPY)  r_board[r_addr]  <= r_next[r_addr];
    end
  end

  // Next-generation buffer, written once per cell on the decide cycle.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_SCAN) && w_decide) r_next[r_addr] <= w_new_cell;
  end

endmodule
